// File: rtl/max_run_pkg.sv
// Shared types and saturating arithmetic helpers for the longest-run stream detector.
package max_run_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Helpers work at a fixed wide width; callers narrow the result to CW bits.
    localparam int MAX_CW = 32;

    function automatic logic [MAX_CW-1:0] satAdd(input logic [MAX_CW-1:0] a,
                                                 input logic [MAX_CW-1:0] b,
                                                 input int cw);
        logic [MAX_CW:0] sum;
        logic [MAX_CW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((MAX_CW + 1)'(1) << cw) - (MAX_CW + 1)'(1);
        if (sum > lim) begin
            return lim[MAX_CW-1:0];
        end
        return sum[MAX_CW-1:0];
    endfunction

    function automatic logic [MAX_CW-1:0] maxOf3(input logic [MAX_CW-1:0] a,
                                                 input logic [MAX_CW-1:0] b,
                                                 input logic [MAX_CW-1:0] c);
        logic [MAX_CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/max_run_stream_if.sv
// Beat input and result output handshakes of the longest-run detector.
interface max_run_stream_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_len;
    logic [CW-1:0] out_words;

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_len, out_words
    );

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_len, out_words
    );
endinterface

// File: rtl/max_run_word.sv
// Per-word run statistics: run from MSB, run ending at LSB, longest inner run, all-target flag.
module max_run_word #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic [W-1:0]  target_i,
    output logic [LW-1:0] lead_o,
    output logic [LW-1:0] trail_o,
    output logic [LW-1:0] inner_o,
    output logic          full_o
);

    logic [LW-1:0] run;
    logic          leadOpen;
    logic          trailOpen;

    // Scan MSB-first for lead and inner runs, then LSB-first for the trailing run.
    always_comb begin
        lead_o    = '0;
        trail_o   = '0;
        inner_o   = '0;
        run       = '0;
        leadOpen  = 1'b1;
        trailOpen = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            if (target_i[i]) begin
                run = run + LW'(1);
                if (run > inner_o) begin
                    inner_o = run;
                end
                if (leadOpen) begin
                    lead_o = lead_o + LW'(1);
                end
            end else begin
                run      = '0;
                leadOpen = 1'b0;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (!target_i[i]) begin
                trailOpen = 1'b0;
            end else if (trailOpen) begin
                trail_o = trail_o + LW'(1);
            end
        end
    end

    assign full_o = &target_i;

endmodule

// File: rtl/max_run_stream.sv
// Streaming longest-run detector: tracks the longest run of target bits across a whole frame.
module max_run_stream
    import max_run_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             reset,
    max_run_stream_if.slave  bus
);

    localparam int LW = $clog2(W + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [CW-1:0] best_q, best_d;
    logic [CW-1:0] words_q, words_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] outLen_q, outLen_d;
    logic [CW-1:0] outWords_q, outWords_d;

    logic          accept;
    logic          firstBeat;
    logic          effMode;
    logic [W-1:0]  target;
    logic [LW-1:0] lead, trail, inner;
    logic          full;
    logic [CW-1:0] curBase, bestBase;
    logic [CW-1:0] runSum, beatBest, beatCur, beatWords;
    logic          resultTaken;

    assign accept      = bus.in_valid && bus.in_ready;
    assign resultTaken = (state_q == DONE) && bus.out_ready;

    // Word count is zero only before the first beat of a frame, since it saturates rather than wraps.
    assign firstBeat = (words_q == '0);
    assign effMode   = firstBeat ? bus.mode : mode_q;
    assign target    = effMode ? ~bus.in_data : bus.in_data;

    max_run_word #(.W(W), .LW(LW)) u_word (
        .target_i (target),
        .lead_o   (lead),
        .trail_o  (trail),
        .inner_o  (inner),
        .full_o   (full)
    );

    assign curBase   = firstBeat ? '0 : cur_q;
    assign bestBase  = firstBeat ? '0 : best_q;
    assign runSum    = CW'(satAdd(MAX_CW'(curBase), MAX_CW'(lead), CW));
    assign beatBest  = CW'(maxOf3(MAX_CW'(bestBase), MAX_CW'(runSum), MAX_CW'(inner)));
    assign beatCur   = full ? CW'(satAdd(MAX_CW'(curBase), MAX_CW'(W), CW)) : CW'(trail);
    assign beatWords = CW'(satAdd(MAX_CW'(words_q), MAX_CW'(1), CW));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (accept && bus.in_last) state_d = DONE;
            DONE:    if (bus.out_ready)         state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // in_ready is masked by reset so no beat is taken while state is being cleared.
    always_comb begin
        bus.in_ready  = (state_q == RUN) && !reset;
        bus.out_valid = (state_q == DONE);
    end

    always_comb begin
        cur_d      = cur_q;
        best_d     = best_q;
        words_d    = words_q;
        mode_d     = mode_q;
        outLen_d   = outLen_q;
        outWords_d = outWords_q;
        if (accept) begin
            cur_d   = beatCur;
            best_d  = beatBest;
            words_d = beatWords;
            mode_d  = effMode;
            if (bus.in_last) begin
                outLen_d   = beatBest;
                outWords_d = beatWords;
            end
        end
        if (resultTaken) begin
            cur_d   = '0;
            best_d  = '0;
            words_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q      <= '0;
            best_q     <= '0;
            words_q    <= '0;
            mode_q     <= 1'b0;
            outLen_q   <= '0;
            outWords_q <= '0;
        end else begin
            cur_q      <= cur_d;
            best_q     <= best_d;
            words_q    <= words_d;
            mode_q     <= mode_d;
            outLen_q   <= outLen_d;
            outWords_q <= outWords_d;
        end
    end

    assign bus.out_len   = outLen_q;
    assign bus.out_words = outWords_q;

endmodule

// File: tb/tb_max_run_stream.sv
// Scoreboard bench for max_run_stream: a bit-serial reference model predicts each frame's result.
module tb_max_run_stream;

    localparam int W   = 8;
    localparam int CW  = 8;
    localparam int SAT = 255;

    typedef struct {
        logic [7:0] data;
        logic       mode;
    } beat_t;

    typedef struct {
        int len;
        int words;
    } result_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;

    beat_t   frameBuf[$];
    result_t expQ[$];

    always #5 clk = ~clk;

    max_run_stream_if #(.W(W), .CW(CW)) bus ();

    max_run_stream #(.W(W), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference walks the frame one bit at a time, MSB first, using the first beat's mode.
    function automatic result_t computeExpected();
        result_t r;
        int      run;
        logic    tgt;
        r.len   = 0;
        run     = 0;
        tgt     = ~frameBuf[0].mode;
        for (int i = 0; i < frameBuf.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (frameBuf[i].data[b] == tgt) run = (run < SAT) ? run + 1 : SAT;
                else run = 0;
                if (run > r.len) r.len = run;
            end
        end
        r.words = (frameBuf.size() < SAT) ? frameBuf.size() : SAT;
        return r;
    endfunction

    task automatic addBeat(input logic [7:0] d, input logic m);
        beat_t b;
        b.data = d;
        b.mode = m;
        frameBuf.push_back(b);
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic applyStimulus(input logic [7:0] d, input logic last, input logic m, input int gap);
        int guard;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.mode     = m;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("inReadyTimeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic sendFrame(input int maxGap);
        int n;
        n = frameBuf.size();
        expQ.push_back(computeExpected());
        for (int i = 0; i < n; i++) begin
            applyStimulus(frameBuf[i].data, (i == n - 1), frameBuf[i].mode,
                          (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
        end
        frameBuf.delete();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (expQ.size() != 0 && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("drainPending", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedResult", 1, 0);
            end else begin
                result_t e;
                e = expQ.pop_front();
                checkOutput("outLen", bus.out_len, e.len);
                checkOutput("outWords", bus.out_words, e.words);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("resetInReady", bus.in_ready, 0);
        checkOutput("resetOutValid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idleInReady", bus.in_ready, 1);
        checkOutput("idleOutLen", bus.out_len, 0);
        checkOutput("idleOutWords", bus.out_words, 0);
        @(posedge clk);
        #1;

        // Single beat: result valid one cycle after acceptance.
        addBeat(8'b01110110, 1'b0);
        sendFrame(0);
        @(negedge clk);
        checkOutput("latencyOutValid", bus.out_valid, 1);
        checkOutput("latencyInReady", bus.in_ready, 0);
        @(posedge clk);
        #1;
        drain();

        addBeat(8'b00000111, 1'b0);
        addBeat(8'b11000000, 1'b0);
        sendFrame(0);
        drain();

        addBeat(8'hFF, 1'b1);
        sendFrame(0);
        addBeat(8'h00, 1'b1);
        sendFrame(0);
        addBeat(8'h00, 1'b1);
        addBeat(8'h00, 1'b0);
        sendFrame(0);
        drain();

        for (int i = 0; i < 40; i++) addBeat(8'hFF, 1'b0);
        sendFrame(0);
        for (int i = 0; i < 300; i++) addBeat(8'hFF, 1'b0);
        sendFrame(0);
        drain();

        // Consumer stalls: result must hold and input must stay blocked.
        bus.out_ready = 1'b0;
        addBeat(8'h3C, 1'b0);
        sendFrame(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("holdOutValid", bus.out_valid, 1);
            checkOutput("holdOutLen", bus.out_len, expQ[0].len);
            checkOutput("holdOutWords", bus.out_words, expQ[0].words);
            checkOutput("holdInReady", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bubbleInReady", bus.in_ready, 1);
        checkOutput("bubbleOutValid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Aborted frame: two beats then reset, no result may appear for them.
        applyStimulus(8'hFF, 1'b0, 1'b0, 0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midResetInReady", bus.in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        addBeat(8'h0F, 1'b0);
        sendFrame(0);
        drain();

        for (int f = 0; f < 6; f++) begin
            logic m;
            int   n;
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) addBeat(8'($urandom), (i == 0) ? m : 1'($urandom_range(0, 1)));
            sendFrame(2);
        end
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
